// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Four requesters share one valid/ready output channel. A round-robin
// arbiter picks one requester at a time and holds the grant for up to
// BURST transfers. After the grant ends, priority moves to the next
// index. A single IDLE cycle always separates two grants.
module mux4_rr_arbiter #(
  parameter int DW    = 1,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic          out_ready,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] out,
  output logic          out_valid
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Counter value on the final transfer of a burst
  localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

  // Convert a 2-bit requester index to its one-hot grant vector
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

  logic [0:0] state_r;
  logic [1:0] ptr_r;
  logic [3:0] cnt_r;

  logic [7:0] req2_s;
  logic [3:0] rot_s;
  logic [1:0] off_s;
  logic       found_s;
  logic [1:0] winner_s;
  logic [DW-1:0] data_sel_s;
  logic       req_sel_s;
  logic       xfer_s;
  logic       release_s;

  // Rotate the request vector so that bit 0 is the requester at ptr.
  // Then take the lowest set bit as the round-robin winner.
  always_comb begin
    req2_s = {req, req};
    rot_s  = req2_s[ptr_r +: 4];
    found_s = |rot_s;
    if (rot_s[0]) begin
      off_s = 2'd0;
    end else if (rot_s[1]) begin
      off_s = 2'd1;
    end else if (rot_s[2]) begin
      off_s = 2'd2;
    end else begin
      off_s = 2'd3;
    end
    winner_s = ptr_r + off_s;
  end

  // Route the granted requester's data and request through the 4:1 mux
  always_comb begin
    case (sel)
      2'd0:    data_sel_s = in0;
      2'd1:    data_sel_s = in1;
      2'd2:    data_sel_s = in2;
      2'd3:    data_sel_s = in3;
      default: data_sel_s = in0;
    endcase
    req_sel_s = req[sel];
  end

  // Valid and data follow same-cycle req and in*. Neither depends on
  // out_ready, so no combinational path exists from ready back to valid.
  always_comb begin
    if (state_r == ST_GRANT) begin
      out_valid = req_sel_s;
    end else begin
      out_valid = 1'b0;
    end
    if (out_valid) begin
      out = data_sel_s;
    end else begin
      out = {DW{1'b0}};
    end
    xfer_s = out_valid & out_ready;
    // Release when the requester withdraws, or when the last transfer of
    // the burst completes. If both happen in the same cycle, only one
    // release takes place.
    if (state_r == ST_GRANT) begin
      release_s = ~req_sel_s | (xfer_s & (cnt_r == CNT_LAST));
    end else begin
      release_s = 1'b0;
    end
  end

  // Arbitration FSM with grant, select, pointer and burst counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      gnt     <= 4'b0000;
      sel     <= 2'd0;
      ptr_r   <= 2'd0;
      cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r <= ST_GRANT;
            gnt     <= onehot4(winner_s);
            sel     <= winner_s;
            cnt_r   <= 4'd0;
          end
        end
        ST_GRANT: begin
          if (release_s) begin
            state_r <= ST_IDLE;
            gnt     <= 4'b0000;
            ptr_r   <= sel + 2'd1;
            cnt_r   <= 4'd0;
          end else if (xfer_s) begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          gnt     <= 4'b0000;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (BURST=4, DW=8).
module tb_mux4_rr_arbiter;

  localparam int DW    = 8;
  localparam int BURST = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] din [4];
  logic          out_ready;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] out;
  logic          out_valid;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.DW(DW), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (din[0]),
    .in1       (din[1]),
    .in2       (din[2]),
    .in3       (din[3]),
    .out_ready (out_ready),
    .gnt       (gnt),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_owner;       // -1 when nobody holds the channel
  int m_sel;
  int m_ptr;
  int m_done;        // transfers completed in the current grant
  bit m_acc [4];     // requester i had data accepted at the last edge

  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_done = 0;
    for (int i = 0; i < 4; i++) m_acc[i] = 1'b0;
  endtask

  task automatic model_check();
    logic [3:0] eg;
    logic       ev;
    logic [7:0] eo;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ev = (m_owner >= 0) && req[m_sel];
    eo = ev ? din[m_sel] : 8'h00;
    chk("rnd_gnt", 32'(gnt), 32'(eg));
    chk("rnd_sel", 32'(sel), 32'(m_sel));
    chk("rnd_valid", 32'(out_valid), 32'(ev));
    chk("rnd_out", 32'(out), 32'(eo));
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) m_acc[i] = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
          m_owner = (m_ptr + k) % 4;
          m_sel   = m_owner;
          m_done  = 0;
        end
      end
    end else if (!req[m_sel]) begin
      m_owner = -1;
      m_ptr   = (m_sel + 1) % 4;
    end else if (out_ready) begin
      m_acc[m_sel] = 1'b1;
      m_done++;
      if (m_done == BURST) begin
        m_owner = -1;
        m_ptr   = (m_sel + 1) % 4;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    logic       e_v;
    logic [7:0] e_out;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // Single requester on input 2: four transfers per grant, one idle gap
    tbl[0]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 8'h00};
    for (int i = 1; i <= 4; i++) tbl[i] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h01};
    tbl[5]  = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 8'h00};
    for (int i = 6; i <= 9; i++) tbl[i] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 8'h01};
    tbl[10] = '{4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 8'h00};

    rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
    din[0] = 8'h10; din[1] = 8'h21; din[2] = 8'h01; din[3] = 8'h43;

    // ---- reset state with all requests high ----
    next_cycle();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_out", 32'(out), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    chk("rst_first_sel", 32'(sel), 32'h0);

    // ---- table: single requester ----
    do_reset();
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req; out_ready = tbl[i].rdy;
      #1;
      chk("tbl_gnt", 32'(gnt), 32'(tbl[i].e_gnt));
      chk("tbl_sel", 32'(sel), 32'(tbl[i].e_sel));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].e_v));
      chk("tbl_out", 32'(out), 32'(tbl[i].e_out));
      next_cycle();
    end

    // ---- full rotation with all four requesting ----
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rot_gap", 32'(gnt), 32'h0);
      next_cycle();
      for (int k = 0; k < ((g < 4) ? BURST : 1); k++) begin
        #1;
        chk("rot_gnt", 32'(gnt), 32'(1 << (g % 4)));
        chk("rot_out", 32'(out), 32'(din[g % 4]));
        next_cycle();
      end
    end

    // ---- backpressure on requester 1 ----
    do_reset();
    req = 4'b0010; din[1] = 8'hA5; out_ready = 1'b0;
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_gnt", 32'(gnt), 32'h2);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_out", 32'(out), 32'hA5);
      next_cycle();
    end
    out_ready = 1'b1;
    for (int k = 0; k < BURST; k++) begin
      #1;
      chk("bp_resume_gnt", 32'(gnt), 32'h2);
      next_cycle();
    end
    #1;
    chk("bp_release", 32'(gnt), 32'h0);

    // ---- withdrawal by requester 3 ----
    do_reset();
    req = 4'b1000; out_ready = 1'b1;
    next_cycle();                       // grant to 3
    #1;
    chk("wd_gnt", 32'(gnt), 32'h8);
    next_cycle();                       // one transfer
    req = 4'b0011;
    #1;
    chk("wd_valid", 32'(out_valid), 32'h0);
    chk("wd_out", 32'(out), 32'h0);
    next_cycle();
    #1;
    chk("wd_idle", 32'(gnt), 32'h0);
    next_cycle();
    #1;
    chk("wd_next_gnt", 32'(gnt), 32'h1);
    chk("wd_next_sel", 32'(sel), 32'h0);

    // ---- reset in the middle of a burst ----
    do_reset();
    req = 4'b0100; out_ready = 1'b1;
    next_cycle();                       // grant to 2
    next_cycle();                       // transfer 1
    next_cycle();                       // transfer 2, count now 2
    #1;
    chk("mr_pre_gnt", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("mr_gnt", 32'(gnt), 32'h0);
    chk("mr_valid", 32'(out_valid), 32'h0);
    chk("mr_out", 32'(out), 32'h0);
    req = 4'b0110;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_regnt", 32'(gnt), 32'h2);
    chk("mr_resel", 32'(sel), 32'h1);

    // ---- randomized traffic against the reference model ----
    do_reset();
    req = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !m_acc[i]) begin
          if ($urandom_range(15) == 0) req[i] = 1'b0;
        end else begin
          req[i] = ($urandom_range(2) == 0);
          din[i] = 8'($urandom);
        end
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      model_check();
      model_edge();
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
